// File: rtl/definitions.sv
// Shared pipeline types for the memory stage and its neighbours.
// Holds the X/M and M/W boundary control/data structs, the handshake
// FSM state type and the registered writeback payload.
package definitions;

  localparam int XLEN = 32;

  typedef logic [4:0]      RegAddr;
  typedef logic [XLEN-1:0] ProgramCounter;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } MW_ctrl;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
  } M_ctrl;

  typedef struct packed {
    RegAddr          dst;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] val;
    logic            alu_zero;
    ProgramCounter   pc_branch;
  } M_data;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } MemState;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rdata;
    RegAddr          dst;
  } W_data;

  // Load data reported for an access abandoned by the watchdog.
  localparam logic [XLEN-1:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_stage_req_fsm.sv
// Data-memory handshake FSM for the memory stage.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   access, is_store  current X/M instruction touches memory / is a store
//   req_ready         memory accepts the request this cycle
//   rsp_valid         load response valid (ignored outside WAIT)
//   req_valid         request valid toward memory
//   complete          access finishes this cycle
//   load_done         a load response is consumed this cycle
//   timed_out         watchdog abandoned the access this cycle
//   stall             access present and not completing
//   mem_err           sticky watchdog flag
// Optional watchdog: MEM_STAGE_TIMEOUT_EN.
module mem_req_fsm
  import definitions::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic access,
  input  logic is_store,
  input  logic req_ready,
  input  logic rsp_valid,
  output logic req_valid,
  output logic complete,
  output logic load_done,
  output logic timed_out,
  output logic stall,
  output logic mem_err
);

  MemState state, state_nxt;
  logic    to_hit;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  // cnt = cycles already spent in REQ/WAIT, so the watchdog fires during
  // the TIMEOUT_CYCLES-th non-idle cycle.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

  assign to_hit = (state != IDLE) && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)         mem_err <= 1'b0;
    else if (to_hit) mem_err <= 1'b1;
  end
`else
  assign to_hit  = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    complete  = 1'b0;
    load_done = 1'b0;
    timed_out = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) begin
          req_valid = 1'b1;
          if (req_ready) begin
            if (is_store) complete  = 1'b1;
            else          state_nxt = WAIT;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        // Watchdog wins over a same-cycle ready so the drop is clean.
        if (to_hit) begin
          timed_out = 1'b1;
          complete  = 1'b1;
          state_nxt = IDLE;
        end else begin
          req_valid = 1'b1;
          if (req_ready) begin
            if (is_store) begin
              complete  = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (to_hit) begin
          timed_out = 1'b1;
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (rsp_valid) begin
          complete  = 1'b1;
          load_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      req_valid = 1'b0;
      complete  = 1'b0;
      load_done = 1'b0;
      timed_out = 1'b0;
      state_nxt = IDLE;
    end
  end

  assign stall = access & ~complete & ~rst;

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues loads/stores to a variable-latency data
// memory, stalls the front end while an access is outstanding, resolves
// branches and registers results into the M/W boundary.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mw_ctrl, m_ctrl, m_data  X/M pipeline register outputs
//   dmem_req_*               request channel (valid/ready)
//   dmem_rsp_*               load response channel (valid only)
//   m_stall                  freeze PC and F/D/X/XM registers
//   pc_src, pc_branch_o      branch redirect
//   w_ctrl, w_alu, w_rdata, w_dst   registered writeback payload
//   mem_err                  sticky watchdog flag
// Optional watchdog: define MEM_STAGE_TIMEOUT_EN (limit TIMEOUT_CYCLES).
// DATA_W must not exceed XLEN of the shared types.
module mem_stage
  import definitions::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  MW_ctrl            mw_ctrl,
  input  M_ctrl             m_ctrl,
  input  M_data             m_data,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [DATA_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [DATA_W-1:0] dmem_rsp_rdata,
  output logic              m_stall,
  output logic              pc_src,
  output ProgramCounter     pc_branch_o,
  output MW_ctrl            w_ctrl,
  output logic [DATA_W-1:0] w_alu,
  output logic [DATA_W-1:0] w_rdata,
  output RegAddr            w_dst,
  output logic              mem_err
);

  logic  access, complete, load_done, timed_out;
  W_data w_q;

  assign access = m_ctrl.mem_read | m_ctrl.mem_write;

  mem_req_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .access   (access),
    .is_store (m_ctrl.mem_write),
    .req_ready(dmem_req_ready),
    .rsp_valid(dmem_rsp_valid),
    .req_valid(dmem_req_valid),
    .complete (complete),
    .load_done(load_done),
    .timed_out(timed_out),
    .stall    (m_stall),
    .mem_err  (mem_err)
  );

  // XM is frozen during a stall, so these stay stable across REQ.
  assign dmem_req_we    = m_ctrl.mem_write;
  assign dmem_req_addr  = m_data.addr[DATA_W-1:0];
  assign dmem_req_wdata = m_data.val[DATA_W-1:0];

  assign pc_src      = m_ctrl.branch & m_data.alu_zero & ~rst;
  assign pc_branch_o = m_data.pc_branch;

  // A stall inserts a bubble (ctrl cleared) but keeps the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ctrl <= '0;
      w_q    <= '0;
    end else if (m_stall) begin
      w_ctrl <= '0;
    end else begin
      w_ctrl  <= mw_ctrl;
      w_q.alu <= m_data.addr;
      w_q.dst <= m_data.dst;
      if (timed_out)      w_q.rdata <= TIMEOUT_RDATA;
      else if (load_done) w_q.rdata <= XLEN'(dmem_rsp_rdata);
    end
  end

  assign w_alu   = w_q.alu[DATA_W-1:0];
  assign w_rdata = w_q.rdata[DATA_W-1:0];
  assign w_dst   = w_q.dst;

  // complete is consumed inside the FSM's stall term.
  logic unused_complete;
  assign unused_complete = complete;

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline memory stage. It consumes the execute/memory pipeline-register outputs (`mw_ctrl`, `m_ctrl`, `m_data`) and runs loads and stores against a variable-latency data memory over a valid/ready request and valid response handshake. While an access is outstanding it stalls the front of the pipeline. It also resolves branches and registers results into the memory/writeback boundary (`w_*`) for the writeback stage.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: watchdog limit. Used only when `MEM_STAGE_TIMEOUT_EN` is defined.
- `DATA_W`, default 32: data and address width.

Ports:
- `clk`  in  1: clock. One clock domain; all state updates on the rising edge.
- `rst`  in  1: reset. Synchronous, active-high.
- `mw_ctrl`  in  MW_ctrl: writeback controls (`reg_write`, `mem_to_reg`), passed through.
- `m_ctrl`  in  M_ctrl: `mem_read`, `mem_write`, `branch`.
- `m_data`  in  M_data: `dst`, `addr`, `val`, `alu_zero`, `pc_branch`.
- `dmem_req_valid`  out  1: request valid.
- `dmem_req_ready`  in  1: memory accepts the request.
- `dmem_req_we`  out  1: 1 = store.
- `dmem_req_addr`  out  DATA_W: driven from `m_data.addr`.
- `dmem_req_wdata`  out  DATA_W: driven from `m_data.val`.
- `dmem_rsp_valid`  in  1: load data valid. Stores get no response.
- `dmem_rsp_rdata`  in  DATA_W: load data.
- `m_stall`  out  1: freeze the PC and the F/D/X/XM registers. Combinational.
- `pc_src`  out  1: take branch. Combinational, equal to `m_ctrl.branch & m_data.alu_zero & !rst`.
- `pc_branch_o`  out  ProgramCounter: equal to `m_data.pc_branch`.
- `w_ctrl`  out  MW_ctrl: registered writeback controls.
- `w_alu`  out  DATA_W: registered `m_data.addr` (the ALU result).
- `w_rdata`  out  DATA_W: registered load data.
- `w_dst`  out  RegAddr: registered destination register.
- `mem_err`  out  1: sticky timeout flag.

## Operation
- Access = `m_ctrl.mem_read | m_ctrl.mem_write`. If both bits are set, it is treated as a store.
- FSM states: IDLE, REQ, WAIT.
  - **IDLE**
    - With an access present, `dmem_req_valid` = 1 combinationally.
    - If `dmem_req_ready`: a store completes and stays in IDLE; a load goes to WAIT.
    - Otherwise go to REQ.
  - **REQ**
    - Hold `dmem_req_valid` = 1 with stable `dmem_req_addr`, `dmem_req_we` and `dmem_req_wdata` until `dmem_req_ready`.
    - On acceptance, a store goes to IDLE and completes that cycle; a load goes to WAIT.
  - **WAIT**
    - `dmem_req_valid` = 0.
    - When `dmem_rsp_valid` = 1, the load completes that cycle and the FSM goes to IDLE.
- `m_stall` = access & !complete_this_cycle. The XM register is frozen while stalled, so the same instruction stays presented and is never re-issued.
- Writeback register update each cycle:
  - If `m_stall`: `w_ctrl` <= 0 (bubble: `reg_write` = 0); all other `w_*` hold.
  - Otherwise: `w_ctrl` <= `mw_ctrl`, `w_alu` <= `m_data.addr`, `w_dst` <= `m_data.dst`, `w_rdata` <= `dmem_rsp_rdata` if a load completed, else holds.
- `dmem_rsp_valid` seen in IDLE or REQ is ignored. This covers stale responses after reset.

## Timing
- Non-memory op: no stall; `w_*` valid one cycle after presentation.
- Store with `dmem_req_ready` high in the first cycle: zero stall cycles.
- Load: stall cycles = (cycles until ready, minimum 1) + response delay.
  - Fastest load (ready in cycle 0, response in cycle 1) = 1 stall cycle.
  - `w_rdata` updates on the edge ending the response cycle.
- Reset values:
  - FSM = IDLE.
  - `w_ctrl`, `w_alu`, `w_rdata`, `w_dst` = 0.
  - `mem_err` = 0.
  - `dmem_req_valid` = 0 and `m_stall` = 0 while `rst` is high.
- Reset mid-access: the access is abandoned and the FSM returns to IDLE on the next edge; the memory side must tolerate an orphaned request.

## Configuration
- **`MEM_STAGE_TIMEOUT_EN` defined:**
  - A counter runs in REQ/WAIT and clears in IDLE.
  - On reaching `TIMEOUT_CYCLES`: drop the request, go to IDLE, complete the instruction with `w_rdata` = 32'hDEADBEEF, and set `mem_err` (sticky until `rst`).
- **Undefined:** no counter; the stage waits indefinitely and `mem_err` is tied to 0.

## Structure
- Package `definitions` holds `M_ctrl`, `MW_ctrl`, `M_data`, `RegAddr` and `ProgramCounter`. Add to it:
  - enum `MemState` {IDLE, REQ, WAIT};
  - struct `W_data` {alu, rdata, dst}.
- Sub-module `mem_req_fsm`: handshake FSM plus optional watchdog; outputs `complete` and `stall`. The top level holds the writeback register and branch logic.

## Test plan
- ALU op, `mw_ctrl.reg_write` = 1, addr = 0x10, dst = 5 -> `m_stall` never asserts; next cycle `w_alu` = 0x10, `w_dst` = 5, `w_ctrl.reg_write` = 1.
- Store to 0x40, val 0xAB, ready held high -> a single request cycle with `dmem_req_we` = 1, zero stall cycles.
- Load from 0x80, ready after 2 cycles, response 3 cycles later -> `m_stall` high for 5 cycles, `w_ctrl` zero during the stall, then `w_rdata` = response data with `reg_write` = 1.
- Branch with `alu_zero` = 1, `pc_branch` = 0x200 -> `pc_src` = 1 and `pc_branch_o` = 0x200 in the same cycle; `alu_zero` = 0 gives `pc_src` = 0.
- `rst` pulsed while in WAIT, then a late `dmem_rsp_valid` -> FSM in IDLE, all `w_*` = 0, response ignored.
- With `MEM_STAGE_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, a load that never gets a response -> stall ends after 4 cycles, `w_rdata` = 0xDEADBEEF, `mem_err` = 1 until reset.
